// File: rtl/usb_gpx_event_ctrl.sv
// Avalon-MM event controller for the MAX3421E GPX/INT pins: synchronizer,
// glitch filter, edge capture into sticky pending flags, irq and GPX event counter.
module usb_gpx_event_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  input  logic [1:0]  in_port
);

  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       filt_q, filt_d, filt_prev_q;
  logic [1:0][7:0]  cnt_q, cnt_d;
  logic [1:0]       ien_q, ien_d;
  logic [1:0]       edge_q, edge_d;
  logic [7:0]       flt_q, flt_d;
  logic [1:0]       pend_q, pend_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [31:0]      count_ext;
  logic [1:0]       qual;
  logic             wr_en;

  assign wr_en = chipselect & ~write_n;

  // >= rather than == so a count already past a newly lowered FLT still commits
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] >= flt_q) filt_d[i] = sync2_q[i];
        else                   cnt_d[i]  = cnt_q[i] + 8'd1;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      qual[i] = edge_q[i] ? (filt_prev_q[i] & ~filt_q[i])
                          : (~filt_prev_q[i] & filt_q[i]);
    end
  end

  always_comb begin
    ien_d  = ien_q;
    edge_d = edge_q;
    flt_d  = flt_q;
    if (wr_en && address == 2'd1) begin
      ien_d  = writedata[1:0];
      edge_d = writedata[3:2];
      flt_d  = writedata[15:8];
    end
  end

  // a new edge wins over a simultaneous clear, for both PEND and COUNT
  always_comb begin
    pend_d = pend_q;
    if (wr_en && address == 2'd2) pend_d = pend_q & ~writedata[1:0];
    pend_d = pend_d | qual;
  end

  always_comb begin
    count_d = count_q;
    if (wr_en && address == 2'd3) count_d = '0;
    if (qual[0]) count_d = count_d + CNT_W'(1);
  end

  always_comb begin
    count_ext = 32'(count_q);
    readdata_d = '0;
    case (address)
      2'd0: readdata_d = {30'd0, filt_q};
      2'd1: readdata_d = {16'd0, flt_q, 4'd0, edge_q, ien_q};
      2'd2: readdata_d = {30'd0, pend_q};
      2'd3: readdata_d = count_ext;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      filt_q      <= '0;
      filt_prev_q <= '0;
      cnt_q       <= '0;
      ien_q       <= '0;
      edge_q      <= '0;
      flt_q       <= '0;
      pend_q      <= '0;
      count_q     <= '0;
      readdata_q  <= '0;
    end else begin
      sync1_q     <= in_port;
      sync2_q     <= sync1_q;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      cnt_q       <= cnt_d;
      ien_q       <= ien_d;
      edge_q      <= edge_d;
      flt_q       <= flt_d;
      pend_q      <= pend_d;
      count_q     <= count_d;
      readdata_q  <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(pend_q & ien_q);

endmodule

// File: tb/tb_usb_gpx_event_ctrl.sv
// Directed bench for usb_gpx_event_ctrl; a narrow-counter instance shares the bus to cover wrap.
module tb_usb_gpx_event_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [1:0]  in_port = '0;
  logic [31:0] readdata, readdata4;
  logic        irq, irq4;
  logic [31:0] rv;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  usb_gpx_event_ctrl dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
    .in_port(in_port)
  );

  usb_gpx_event_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata4), .irq(irq4),
    .in_port(in_port)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    tick();
    d = readdata;
  endtask

  task automatic gpx_pulse();
    in_port[0] = 1'b1;
    tick(2);
    in_port[0] = 1'b0;
    tick(2);
  endtask

  initial begin
    // reset state
    tick(3);
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    reset_n = 1'b1;
    tick(2);
    rd(2'd1, rv); check("rst_ctrl", rv, 32'h0);
    rd(2'd2, rv); check("rst_pend", rv, 32'h0);
    rd(2'd3, rv); check("rst_count", rv, 32'h0);

    // FLT=0 latency: DATA valid 4 cycles after the pin change
    address = 2'd0;
    in_port[0] = 1'b1;
    tick(3);
    check("data_lat3", readdata, 32'h0);
    tick();
    check("data_lat4", readdata, 32'h1);
    rd(2'd2, rv); check("pend_first_edge", rv, 32'h1);
    check("irq_ien0", {31'd0, irq}, 32'h0);
    rd(2'd3, rv); check("count_first", rv, 32'h1);
    wr(2'd2, 32'h1);
    rd(2'd2, rv); check("pend_w1c", rv, 32'h0);

    // CTRL unused bits, then FLT=5 with IEN0
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, rv); check("ctrl_mask", rv, 32'h0000_FF0F);
    wr(2'd1, 32'h0000_0501);
    rd(2'd1, rv); check("ctrl_rb", rv, 32'h0000_0501);
    in_port[0] = 1'b0;
    tick(12);
    check("fall_no_irq", {31'd0, irq}, 32'h0);
    in_port[0] = 1'b1;
    tick(5);
    in_port[0] = 1'b0;
    tick(15);
    rd(2'd0, rv); check("short_data", rv, 32'h0);
    rd(2'd2, rv); check("short_pend", rv, 32'h0);
    in_port[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 8) check("long_irq_c8", {31'd0, irq}, 32'h0);
      if (k == 9) check("long_irq_c9", {31'd0, irq}, 32'h1);
    end
    in_port[0] = 1'b0;
    tick(12);
    rd(2'd2, rv); check("long_pend", rv, 32'h1);
    wr(2'd2, 32'h1);
    check("irq_after_w1c", {31'd0, irq}, 32'h0);

    // INT channel on falling edge
    wr(2'd1, 32'h0000_050B);
    in_port[1] = 1'b1;
    tick(12);
    check("int_rise_irq", {31'd0, irq}, 32'h0);
    rd(2'd2, rv); check("int_rise_pend", rv, 32'h0);
    in_port[1] = 1'b0;
    tick(12);
    check("int_fall_irq", {31'd0, irq}, 32'h1);
    rd(2'd2, rv); check("int_fall_pend", rv, 32'h2);
    wr(2'd2, 32'h2);
    check("int_w1c_irq", {31'd0, irq}, 32'h0);

    // W1C coinciding with a qualifying GPX edge (FLT=0)
    wr(2'd1, 32'h0000_000B);
    in_port[0] = 1'b1;
    tick(3);
    wr(2'd2, 32'h1);
    rd(2'd2, rv); check("set_wins_pend", rv, 32'h1);
    check("set_wins_irq", {31'd0, irq}, 32'h1);
    wr(2'd2, 32'h3);
    in_port[0] = 1'b0;
    tick(6);

    // counter: 16-bit and 4-bit instances see the same edges
    rd(2'd3, rv); check("count3", rv, 32'h3);
    check("count3_w4", readdata4, 32'h3);
    wr(2'd3, 32'h0);
    rd(2'd3, rv); check("count_clear", rv, 32'h0);
    for (int k = 0; k < 15; k++) gpx_pulse();
    tick(4);
    rd(2'd3, rv); check("count15", rv, 32'd15);
    check("count15_w4", readdata4, 32'd15);
    gpx_pulse();
    tick(4);
    rd(2'd3, rv); check("count16", rv, 32'd16);
    check("count_wrap_w4", readdata4, 32'd0);
    in_port[0] = 1'b1;
    tick(3);
    wr(2'd3, 32'h0);
    rd(2'd3, rv); check("count_clr_edge", rv, 32'h1);
    check("count_clr_edge_w4", readdata4, 32'h1);
    in_port[0] = 1'b0;
    tick(6);
    wr(2'd2, 32'h3);

    // IEN gating, then reset mid-filter with irq high (FLT=8)
    wr(2'd1, 32'h0000_0801);
    in_port[0] = 1'b1;
    tick(14);
    check("pre_irq", {31'd0, irq}, 32'h1);
    wr(2'd1, 32'h0000_0800);
    check("ien_off_irq", {31'd0, irq}, 32'h0);
    rd(2'd2, rv); check("ien_off_pend", rv, 32'h1);
    wr(2'd1, 32'h0000_0801);
    check("ien_on_irq", {31'd0, irq}, 32'h1);
    in_port[0] = 1'b0;
    tick(5);
    reset_n = 1'b0;
    #1;
    check("arst_irq", {31'd0, irq}, 32'h0);
    check("arst_readdata", readdata, 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(20);
    check("post_irq", {31'd0, irq}, 32'h0);
    rd(2'd2, rv); check("post_pend", rv, 32'h0);
    rd(2'd3, rv); check("post_count", rv, 32'h0);
    rd(2'd1, rv); check("post_ctrl", rv, 32'h0);
    rd(2'd0, rv); check("post_data", rv, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/usb_gpx_event_ctrl.md
# usb_gpx_event_ctrl

Avalon-MM event controller for the MAX3421E USB host chip's GPX and INT pins on the Imersiv SoC; it replaces the plain input PIO on those pins. Each pin is synchronized and glitch-filtered, and selected edges are captured into sticky pending flags. It raises an interrupt to the Nios II when an enabled flag is set and counts GPX edges for the USB driver. Software configures the block, polls it and acknowledges events through four 32-bit registers.

## Interface
Parameters:
- CNT_W, default 16: width of the GPX event counter.

Ports:
- clk  in  1  system clock; one clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  Avalon word address.
- chipselect  in  1  Avalon select.
- write_n  in  1  Avalon write strobe, active low. A write occurs when chipselect=1 and write_n=0.
- writedata  in  32  Avalon write data.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt to the CPU, active high.
- in_port  in  2  asynchronous pins: bit0 = GPX, bit1 = INT.

## Operation
Register map:
- 0 DATA (RO): [1:0] filtered pin levels.
- 1 CTRL (RW): [1:0] IEN, per-channel irq enable. [3:2] EDGE, per channel: 0 = rising, 1 = falling. [15:8] FLT, filter length. Other bits read 0.
- 2 PEND (W1C): [1:0] sticky pending edge flags.
- 3 COUNT: [CNT_W-1:0] count of qualifying GPX edges. Any write clears it.

Per-channel pipeline:
- Synchronizer: 2-flop chain, in_port -> s.
- Filter state: filt, plus an 8-bit counter cnt.
  - If s==filt: cnt<=0.
  - Else if cnt>=FLT: filt<=s and cnt<=0.
  - Else: cnt<=cnt+1.
  - Net effect: filt follows s only after s has differed for FLT+1 consecutive cycles. FLT=0 gives no filtering beyond 1 cycle.
  - The >= comparison guarantees a commit when FLT is lowered mid-count.
- Qualifying edge: filt changes 0->1 with EDGE=0, or 1->0 with EDGE=1. Detected from the registered previous filt value; it is a single-cycle pulse.
- Pending: PEND[i] is set on a qualifying edge. Writing 1 to bit i clears it. If a set and a clear land in the same cycle, the set wins.
- Counter: increments on each qualifying GPX edge, regardless of IEN, and wraps from all-ones to 0. If a write to COUNT coincides with an edge, the result is 1.
- irq = |(PEND & IEN), driven from registers with no combinational path from inputs.
  - Clearing IEN deasserts irq without losing PEND.
  - Setting IEN while PEND is already set asserts irq.
- Reset: filt resets to 0. A pin held high through reset therefore produces one rising edge after release; the driver clears PEND after init.
- Writes to DATA and to unused bits are ignored.

## Timing
- Reset values: readdata=0, irq=0, CTRL=0, PEND=0, COUNT=0, sync flops=0, filt=0, cnt=0.
- Read latency: readdata is updated every clk from address (chipselect is ignored for reads), so data is valid 1 cycle after address is presented. Reads have no side effects.
- Write: takes effect on the clk edge where the write strobe is sampled. A read of the same register in the next cycle returns the new value.
- Pin to filt: 2 sync cycles + (FLT+1) cycles.
- filt to PEND/COUNT: +1 cycle.
- PEND to irq: 0 cycles, since irq is combinational from registers.
- Pin to readdata DATA: filt latency + 1.
- Pulses shorter than FLT+1 cycles after synchronization never reach filt.
- Asserting reset_n low mid-filter, or with irq asserted, clears everything immediately, with no pending edge generated.

## Test plan
- Reset, CTRL=0, GPX driven 0->1 and held. Required: DATA[0]=1 at cycle 4 after the pin change (2 sync + 1 filter + 1 readdata). PEND=01 at cycle 4. irq stays 0.
- CTRL=0x0000_0501 (FLT=5, IEN0). Apply a 5-cycle GPX pulse, then a 10-cycle GPX pulse. Required: the 5-cycle pulse causes no change. The 10-cycle pulse sets PEND[0] and irq=1 at 2+6+1 cycles after the rising edge. Write PEND=1: irq=0 the next cycle.
- EDGE1=1, IEN1=1. Drive INT 1->0. Required: PEND[1]=1 and irq=1. An INT 0->1 transition does not set PEND.
- Issue a PEND W1C write in the same cycle as a qualifying GPX edge. Required: PEND[0] remains 1.
- With CNT_W=16 and COUNT preloaded to 0xFFFF via 65535 edges, or forced in simulation, apply 1 edge. Required: COUNT=0. Write COUNT coinciding with an edge: required COUNT=1.
- Assert reset_n mid-filter (cnt=3, FLT=8) with irq=1. Required: all outputs are 0 immediately. After release with the pin low, no event occurs.
